// File: rtl/frame_sequencer.sv
`timescale 1ns/1ps
// Front-end controller: streams a raster frame into the detection pipeline, drains it with flush pixels, then walks
// every label's stats out over a valid/ready stream. Pixels reach the pipeline 1 cycle after accept; stats beats hold under back-pressure.
module frame_sequencer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int LOC_SIZE     = 11,
  parameter int LBL_WIDTH    = 8,
  parameter int PIXEL_SIZE   = 24,
  parameter int FLUSH_PIXELS = 1288,
  parameter int STAT_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIXEL_SIZE-1:0] in_data,
  output logic                  pix_en,
  output logic [LOC_SIZE-1:0]   pix_x,
  output logic [LOC_SIZE-1:0]   pix_y,
  output logic [PIXEL_SIZE-1:0] pix_data,
  input  logic [LBL_WIDTH-1:0]  num_labels,
  output logic [LBL_WIDTH-1:0]  obj_id,
  input  logic [LOC_SIZE-1:0]   obj_area,
  input  logic [LOC_SIZE-1:0]   obj_x,
  input  logic [LOC_SIZE-1:0]   obj_y,
  output logic                  stat_valid,
  input  logic                  stat_ready,
  output logic [LBL_WIDTH-1:0]  stat_id,
  output logic [LOC_SIZE-1:0]   stat_area,
  output logic [LOC_SIZE-1:0]   stat_x,
  output logic [LOC_SIZE-1:0]   stat_y,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int FCW = $clog2(FLUSH_PIXELS + 1);
  localparam logic [LOC_SIZE-1:0] X_LAST     = LOC_SIZE'(FRAME_WIDTH - 1);
  localparam logic [LOC_SIZE-1:0] Y_LAST     = LOC_SIZE'(FRAME_HEIGHT - 1);
  localparam logic [LOC_SIZE-1:0] Y_OUT      = LOC_SIZE'(FRAME_HEIGHT);
  localparam logic [FCW-1:0]      FLUSH_LAST = FCW'(FLUSH_PIXELS - 1);
  localparam logic [3:0]          WAIT_INIT  = 4'(STAT_LATENCY);

  typedef enum logic [2:0] {
    IDLE, STREAM, FLUSH, SCAN_SET, SCAN_WAIT, SCAN_OUT, DONE
  } state_t;

  state_t               state;
  logic [LOC_SIZE-1:0]  col;
  logic [LOC_SIZE-1:0]  row;
  logic [FCW-1:0]       flush_cnt;
  logic [LBL_WIDTH-1:0] nl;
  logic [LBL_WIDTH-1:0] next_id;
  logic [3:0]           wait_cnt;

  assign in_ready = (state == STREAM);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      flush_cnt  <= '0;
      nl         <= '0;
      next_id    <= '0;
      wait_cnt   <= '0;
      pix_en     <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      obj_id     <= '0;
      stat_valid <= 1'b0;
      stat_id    <= '0;
      stat_area  <= '0;
      stat_x     <= '0;
      stat_y     <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_en     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            col   <= '0;
            row   <= '0;
          end
        end
        // in_ready is high for the whole state, so in_valid alone marks an accept
        STREAM: begin
          if (in_valid) begin
            pix_en   <= 1'b1;
            pix_data <= in_data;
            pix_x    <= col;
            pix_y    <= row;
            if (col == X_LAST) begin
              col <= '0;
              row <= row + 1'b1;
              if (row == Y_LAST) begin
                state     <= FLUSH;
                flush_cnt <= '0;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        // col has wrapped to 0 on the last accept, so it doubles as the flush column
        FLUSH: begin
          pix_en   <= 1'b1;
          pix_data <= '0;
          pix_x    <= col;
          pix_y    <= Y_OUT;
          col      <= (col == X_LAST) ? '0 : col + 1'b1;
          if (flush_cnt == FLUSH_LAST) begin
            state   <= SCAN_SET;
            nl      <= num_labels;
            next_id <= LBL_WIDTH'(1);
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        SCAN_SET: begin
          if (nl == '0) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            obj_id   <= next_id;
            wait_cnt <= WAIT_INIT;
            state    <= SCAN_WAIT;
          end
        end
        SCAN_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == 4'd1) begin
            stat_area  <= obj_area;
            stat_x     <= obj_x;
            stat_y     <= obj_y;
            stat_id    <= obj_id;
            stat_valid <= 1'b1;
            state      <= SCAN_OUT;
          end
        end
        // compare before incrementing so nl of all ones never wraps obj_id
        SCAN_OUT: begin
          if (stat_ready) begin
            stat_valid <= 1'b0;
            if (obj_id == nl) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              next_id <= obj_id + 1'b1;
              state   <= SCAN_SET;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for frame_sequencer on a 4x3 frame with a one-register stats model behind obj_id.
module tb_frame_sequencer;
  localparam int W = 4, H = 3, FP = 5, SL = 2, LOC = 11, LBL = 8, PIX = 24;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, pix_en, stat_valid, stat_ready, busy, frame_done;
  logic [PIX-1:0] in_data, pix_data;
  logic [LOC-1:0] pix_x, pix_y, obj_area, obj_x, obj_y, stat_area, stat_x, stat_y;
  logic [LBL-1:0] num_labels, obj_id, stat_id, id_d1;

  typedef struct packed { logic [LOC-1:0] x; logic [LOC-1:0] y; logic [PIX-1:0] data; } pix_t;
  typedef struct packed { logic [LBL-1:0] id; logic [LOC-1:0] area; logic [LOC-1:0] x; logic [LOC-1:0] y; } beat_t;

  pix_t  pq[$];
  beat_t sq[$];
  int checks = 0, failures = 0;
  int cyc_n = 0, id_chg_cyc = 0, last_pix_cyc = 0, last_hs_cyc = 0, done_cyc = 0, done_cnt = 0;
  int m_col = 0, m_row = 0, bp_id = 0, bp_n = 0;
  bit m_stream = 0, m_busy = 0;
  logic prev_sv = 1'b0, prev_sr = 1'b0, prev_fd = 1'b0;
  logic [LOC-1:0] prev_area = '0, prev_x = '0, prev_y = '0;
  logic [LBL-1:0] prev_sid = '0, prev_obj = '0;

  always #5 clk = ~clk;

  frame_sequencer #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .LOC_SIZE(LOC), .LBL_WIDTH(LBL),
    .PIXEL_SIZE(PIX), .FLUSH_PIXELS(FP), .STAT_LATENCY(SL)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .num_labels(num_labels), .obj_id(obj_id),
    .obj_area(obj_area), .obj_x(obj_x), .obj_y(obj_y),
    .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_id(stat_id),
    .stat_area(stat_area), .stat_x(stat_x), .stat_y(stat_y),
    .busy(busy), .frame_done(frame_done)
  );

  // stats pipeline stand-in: values settle one register after obj_id moves
  always @(posedge clk) id_d1 <= obj_id;
  assign obj_area = LOC'(10 * id_d1);
  assign obj_x    = LOC'(id_d1 + 1);
  assign obj_y    = LOC'(3 * id_d1 + 7);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // holds stat_ready low for 7 cycles while beat bp_id is offered
  initial begin
    stat_ready = 1'b1;
    forever begin
      cyc();
      if (stat_valid && stat_id == LBL'(bp_id) && bp_n < 7) begin
        stat_ready = 1'b0;
        bp_n++;
      end else begin
        stat_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    pix_t  e;
    beat_t b;
    cyc_n++;
    if (reset) begin
      pq.delete();
      m_stream = 0;
      m_busy   = 0;
      m_col    = 0;
      m_row    = 0;
    end else begin
      chk("pix_en", pix_en, pq.size() != 0);
      if (pq.size() != 0) begin
        e = pq.pop_front();
        if (pix_en) begin
          chk("pix_x", pix_x, e.x);
          chk("pix_y", pix_y, e.y);
          chk("pix_data", pix_data, e.data);
        end
      end
      if (pix_en) last_pix_cyc = cyc_n;
      chk("in_ready", in_ready, m_stream);
      chk("busy", busy, m_busy);
      if (prev_sv && !prev_sr) begin
        chk("hold_vld", stat_valid, 1);
        chk("hold_id", stat_id, prev_sid);
        chk("hold_area", stat_area, prev_area);
        chk("hold_x", stat_x, prev_x);
        chk("hold_y", stat_y, prev_y);
        chk("hold_obj", obj_id, prev_obj);
      end
      if (stat_valid && !prev_sv) chk("stat_lat", cyc_n - id_chg_cyc, SL);
      if (stat_valid && stat_ready) begin
        last_hs_cyc = cyc_n;
        if (sq.size() == 0) chk("stat_extra", sq.size(), 1);
        else begin
          b = sq.pop_front();
          chk("stat_id", stat_id, b.id);
          chk("stat_area", stat_area, b.area);
          chk("stat_x", stat_x, b.x);
          chk("stat_y", stat_y, b.y);
        end
      end
      if (frame_done) begin
        chk("done_width", prev_fd, 0);
        done_cnt++;
        done_cyc = cyc_n;
        m_busy = 0;
      end
      if (in_valid && m_stream) begin
        e.x = LOC'(m_col);
        e.y = LOC'(m_row);
        e.data = in_data;
        pq.push_back(e);
        if (m_col == W - 1) begin
          m_col = 0;
          if (m_row == H - 1) begin
            m_stream = 0;
            for (int k = 0; k < FP; k++) begin
              e.x = LOC'(k % W);
              e.y = LOC'(H);
              e.data = '0;
              pq.push_back(e);
            end
          end else m_row++;
        end else m_col++;
      end
      if (start && !m_busy) begin
        m_busy = 1; m_stream = 1; m_col = 0; m_row = 0;
      end
    end
    if (obj_id !== prev_obj) id_chg_cyc = cyc_n;
    prev_sv = stat_valid; prev_sr = stat_ready; prev_fd = frame_done;
    prev_sid = stat_id; prev_area = stat_area; prev_x = stat_x; prev_y = stat_y;
    prev_obj = obj_id;
  end

  task automatic send_pixels(input bit toggle, input int start_at, input int seed);
    logic r;
    int t;
    for (int i = 0; i < W * H; i++) begin
      in_valid = 1'b1;
      in_data  = PIX'(seed * 16 + i + 1);
      if (i == start_at) start = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        r = in_ready;
        cyc();
        start = 1'b0;
        t++;
      end while (!r && t < 100);
      if (!r) chk("accept_timeout", r, 1);
      if (toggle) begin
        in_valid = 1'b0;
        cyc();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_pix_en"}, pix_en, 0);
    chk({pfx, "_pix_x"}, pix_x, 0);
    chk({pfx, "_pix_y"}, pix_y, 0);
    chk({pfx, "_pix_data"}, pix_data, 0);
    chk({pfx, "_obj_id"}, obj_id, 0);
    chk({pfx, "_stat_valid"}, stat_valid, 0);
    chk({pfx, "_stat_id"}, stat_id, 0);
    chk({pfx, "_stat_area"}, stat_area, 0);
    chk({pfx, "_stat_x"}, stat_x, 0);
    chk({pfx, "_stat_y"}, stat_y, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_frame_done"}, frame_done, 0);
  endtask

  task automatic run_frame(input int nl, input bit toggle, input int start_at, input int bp, input int seed);
    beat_t b;
    int base, t;
    num_labels = LBL'(nl);
    bp_id = bp;
    bp_n  = 0;
    base  = done_cnt;
    for (int id = 1; id <= nl; id++) begin
      b.id = LBL'(id);
      b.area = LOC'(10 * id);
      b.x = LOC'(id + 1);
      b.y = LOC'(3 * id + 7);
      sq.push_back(b);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    send_pixels(toggle, start_at, seed);
    t = 0;
    while (done_cnt == base && t < 5000) begin
      cyc();
      t++;
    end
    chk("done_seen", done_cnt - base, 1);
    cyc();
    cyc();
    chk("done_once", done_cnt - base, 1);
    chk("beats_left", sq.size(), 0);
    chk("idle_busy", busy, 0);
    if (nl == 0) chk("done_lat_empty", done_cyc - last_pix_cyc, 1);
    else chk("done_lat", done_cyc - last_hs_cyc, 1);
    sq.delete();
  endtask

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; num_labels = '0;
    cyc();
    cyc();
    check_zero("rst");
    reset = 1'b0;
    cyc();

    run_frame(3, 0, -1, 0, 0);      // back-to-back pixels
    run_frame(3, 1, -1, 2, 1);      // gapped pixels, beat 2 back-pressured
    run_frame(0, 0, -1, 0, 2);      // no objects

    // abandon a frame mid-flush
    num_labels = LBL'(2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    send_pixels(0, -1, 3);
    cyc();
    base = done_cnt;
    reset = 1'b1;
    cyc();
    check_zero("midrst");
    reset = 1'b0;
    repeat (20) cyc();
    chk("midrst_no_done", done_cnt - base, 0);
    chk("midrst_busy", busy, 0);

    run_frame(2, 0, 5, 0, 4);       // stray start mid-stream
    run_frame(255, 0, -1, 0, 5);    // full label range

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Front-end controller for the detection pipeline.
- Accepts a raster pixel stream over a valid/ready handshake and drives the pipeline's en/x/y/data inputs.
- After the last pixel, pushes flush pixels so the line-buffered Sobel, flood and connected-components stages drain.
- Then walks obj_id from 1 to num_labels, returning each object's area/x/y as a handshaked stats stream and pulsing frame_done.

Parameters:
- FRAME_WIDTH, 640, pixels per row.
- FRAME_HEIGHT, 480, rows per frame.
- LOC_SIZE, 11, width of x/y/area fields.
- LBL_WIDTH, 8, label/obj_id width.
- PIXEL_SIZE, 24, RGB pixel width.
- FLUSH_PIXELS, 1288, zero pixels injected after the frame (2*FRAME_WIDTH+8); must be at least 1.
- STAT_LATENCY, 2, cycles from an obj_id change to valid obj_area/obj_x/obj_y; range 1..15.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse; begins a frame when idle.
- in_valid, in, 1, in_data valid.
- in_ready, out, 1, sequencer accepts a pixel this cycle.
- in_data, in, PIXEL_SIZE, raster-order RGB pixel.
- pix_en, out, 1, pipeline enable (drives pipeline en).
- pix_x, out, LOC_SIZE, column of pix_data.
- pix_y, out, LOC_SIZE, row of pix_data.
- pix_data, out, PIXEL_SIZE, pixel to pipeline.
- num_labels, in, LBL_WIDTH, label count from pipeline.
- obj_id, out, LBL_WIDTH, object select to pipeline.
- obj_area / obj_x / obj_y, in, LOC_SIZE each, stats for obj_id.
- stat_valid, out, 1, stats beat valid.
- stat_ready, in, 1, consumer accepts the stats beat.
- stat_id, out, LBL_WIDTH, id of the beat.
- stat_area / stat_x / stat_y, out, LOC_SIZE each, captured stats.
- busy, out, 1, high in any state other than IDLE.
- frame_done, out, 1, one-cycle pulse at end of frame.

Behaviour:
- Reset (synchronous, reset=1 at posedge) from any state:
  - state goes to IDLE.
  - All outputs go to 0: in_ready, pix_en, pix_x, pix_y, pix_data, obj_id, stat_*, busy, frame_done.
  - All counters are cleared. A mid-frame reset abandons the frame; no frame_done is issued.
- States: IDLE, STREAM, FLUSH, SCAN_SET, SCAN_WAIT, SCAN_OUT, DONE.
- IDLE:
  - in_ready=0, pix_en=0.
  - start=1 -> STREAM; col/row counters are cleared.
  - start is ignored in every other state.
- STREAM:
  - in_ready=1 (combinational from state).
  - Accept occurs on a cycle with in_valid & in_ready.
  - Next cycle after an accept: pix_en=1, pix_data=in_data, pix_x=col, pix_y=row; otherwise pix_en=0 and pix_x/pix_y/pix_data hold. Latency is 1 cycle.
  - On accept, col increments; at FRAME_WIDTH-1 col wraps to 0 and row increments.
  - Accept at (FRAME_WIDTH-1, FRAME_HEIGHT-1) -> FLUSH; in_ready drops in the following cycle.
- FLUSH:
  - Runs FLUSH_PIXELS cycles, with pix_en=1 and pix_data=0 every cycle.
  - pix_x counts 0..FRAME_WIDTH-1, wrapping.
  - pix_y=FRAME_HEIGHT (out of frame, so no stats are accumulated).
  - After the last flush cycle -> SCAN_SET; pix_en=0 from then on.
- SCAN_SET:
  - On entry from FLUSH, num_labels is latched into nl.
  - If nl==0 -> DONE.
  - Otherwise obj_id=next id (first id is 1) and the wait counter loads STAT_LATENCY -> SCAN_WAIT.
- SCAN_WAIT:
  - Counter decrements each cycle.
  - When it reaches 0: capture obj_area/obj_x/obj_y into stat_area/stat_x/stat_y, set stat_id=obj_id, set stat_valid=1 -> SCAN_OUT.
- SCAN_OUT:
  - stat_valid and stat_* are held stable until stat_ready=1.
  - On the handshake, stat_valid=0 in the next cycle.
  - If obj_id==nl -> DONE; else obj_id+1 -> SCAN_SET (no re-latch of num_labels).
  - nl = 2^LBL_WIDTH-1 must finish without obj_id wrapping to 0.
- DONE: frame_done=1 for exactly one cycle -> IDLE. obj_id holds its last value.
- in_valid while in_ready=0 is ignored; no pixel is consumed.

Test Plan:
- W=4, H=3, FLUSH_PIXELS=5, STAT_LATENCY=2; start, then 12 back-to-back pixels 0x000001..0x00000C:
  - pix_en high for 12+5 cycles.
  - pix_x/pix_y sequence (0,0),(1,0)..(3,2).
  - Flush beats have pix_data=0 and pix_y=3.
  - in_ready low after the 12th accept.
- Same frame with in_valid toggling every other cycle -> each pixel appears exactly once, in order, each 1 cycle after its accept; no pix_en on idle gaps.
- num_labels=3, stats model returns area=10*id, stat_ready tied 1:
  - three beats, stat_id 1,2,3, stat_area 10,20,30, each arriving 2 cycles after obj_id changes.
  - Then a single frame_done pulse, then busy=0.
- num_labels=0 -> no stat_valid; frame_done 1 cycle after SCAN_SET.
- Beat 2 back-pressured (stat_ready=0) for 7 cycles -> stat_valid and stat_* stable for all 7 cycles; obj_id does not advance.
- Reset asserted during FLUSH, then start during STREAM of the next frame:
  - reset returns IDLE with all outputs 0 and no frame_done.
  - start during STREAM has no effect; the frame completes normally.
